hwpe_tiled_fsm: RTL
===================

# hwpe_tiled_fsm

Parametrised HWPE control FSM that sequences N_SRC source and N_SNK sink streamers and one engine over a programmable number of tiles. Between tiles it advances each stream's base address by a per-stream tile stride. It sits between the slave register file and the streamer/engine, replacing the per-accelerator single-pass control FSM. Unlike that FSM, it supports multi-tile jobs, any stream count, and an optional stall watchdog.

## Interface
Parameters:
- N_SRC, 2, number of source streams (≥1)
- N_SNK, 1, number of sink streams (≥1)
- ADDR_W, 32, address width
- CNT_W, 32, engine output-count width
- TILE_W, 16, tile counter width
- WDOG_W, 16, watchdog counter width

Ports (clock and reset first):
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous soft clear; forces IDLE
- start_i  in  1  job start pulse from slave
- n_tiles_i  in  TILE_W  tiles per job; 0 treated as 1
- cnt_limit_i  in  CNT_W  engine outputs per tile
- src_base_i / src_stride_i  in  N_SRC*ADDR_W  per-source base, per-tile stride (packed, stream 0 at LSB)
- snk_base_i / snk_stride_i  in  N_SNK*ADDR_W  per-sink base, per-tile stride
- src_ready_start_i  in  N_SRC;  snk_ready_start_i  in  N_SNK  streamer ready flags
- src_req_start_o  out  N_SRC;  snk_req_start_o  out  N_SNK  streamer start requests
- src_base_addr_o  out  N_SRC*ADDR_W;  snk_base_addr_o  out  N_SNK*ADDR_W  current-tile base addresses
- eng_ready_i  in  1;  eng_cnt_i  in  CNT_W  engine ready and output count
- eng_start_o, eng_clear_o, eng_enable_o  out  1  engine control
- tile_idx_o  out  TILE_W  current tile index
- busy_o, done_o, evt_o  out  1  status; done_o and evt_o are 1-cycle pulses
- wdog_limit_i  in  WDOG_W;  timeout_o  out  1  watchdog (see Configuration)

## Operation
- all_ready = AND of every src_ready_start_i and snk_ready_start_i bit.
- On start_i, the FSM latches n_tiles, cnt_limit, bases and strides. Later input changes do not affect a running job.
- States and transitions:
  - IDLE: eng_clear_o=1. On start_i, go to WAIT with tile_idx=0 and offsets=0.
  - WAIT: if all_ready, pulse every req_start bit and eng_start_o, then go to COMPUTE.
  - COMPUTE: eng_enable_o=1; eng_start_o=eng_ready_i. When eng_cnt_i==cnt_limit, go to UPDATE.
  - UPDATE: if tile_idx+1==n_tiles, go to DRAIN. Otherwise assert eng_clear_o for 1 cycle, increment tile_idx, add stride to each offset, and go to WAIT.
  - DRAIN: if all_ready, pulse done_o and evt_o, then go to IDLE.
- Base address output per stream = latched base + offset, registered, mod 2^ADDR_W (wrap, no saturation).
- busy_o=1 in every state except IDLE.
- start_i outside IDLE is ignored.
- cnt_limit=0: COMPUTE exits on its first cycle, because the engine count is cleared.

## Timing
- Reset value of every output is 0. After reset release, the first IDLE cycle drives eng_clear_o=1.
- clear_i has priority over all transitions. The cycle after clear_i the FSM is in IDLE, offsets and tile_idx are 0, and no pulse is emitted.
- Asserting rst_i mid-job aborts immediately with no done_o.
- req_start and eng_start_o are Mealy outputs: asserted in the same cycle WAIT sees all_ready.
- Latency from start_i at cycle t to req_start: t+1 minimum.
- Latency from the limit match in COMPUTE at cycle t to done_o: t+2 minimum.
- Tile-to-tile gap, limit match to next req_start: 2 cycles minimum.
- Updated src/snk_base_addr_o values are valid in the first WAIT cycle of the new tile.

## Configuration
- HWPE_FSM_WDOG_EN defined:
  - A WDOG_W counter runs in WAIT, COMPUTE and DRAIN, and resets on any state change or any change of eng_cnt_i.
  - When the counter equals a nonzero wdog_limit_i, the FSM pulses timeout_o and done_o together and goes to IDLE.
  - wdog_limit_i=0 disables the watchdog.
- HWPE_FSM_WDOG_EN undefined: no counter is built, timeout_o is tied 0 and wdog_limit_i is unused. The ports exist in both builds.

## Test plan
- N_SRC=2, N_SNK=1, n_tiles=1, cnt_limit=4, streamers always ready, engine counts 0..4 → exactly one req_start pulse on all 3 streams; done_o is 2 cycles after eng_cnt_i==4.
- n_tiles=3, src0 base 0x1000 with stride 0x100 → src_base_addr_o[0] sequence 0x1000, 0x1100, 0x1200; 3 req_start pulses; eng_clear_o pulses twice mid-job; single done_o.
- snk_ready_start_i held low for 5 cycles in WAIT → no req_start during those cycles; req_start in the same cycle ready rises.
- clear_i asserted mid-COMPUTE at tile 1 → next cycle busy_o=0, tile_idx_o=0, no done_o; a following start_i runs the job normally.
- Base 0xFFFF_FF00, stride 0x200, n_tiles=2 → second tile address 0x0000_0100 (wrap).
- With HWPE_FSM_WDOG_EN, wdog_limit=8, engine count frozen → timeout_o and done_o pulse on the 8th stalled cycle, FSM returns to IDLE. Without the macro → timeout_o stays 0 and the FSM stays in COMPUTE.

Source files
------------

// File: rtl/hwpe_tiled_fsm_if.sv
// Streamer/engine control bundle for hwpe_tiled_fsm.
// master: FSM side (drives req/start/clear/enable, base addresses).
// slave : streamer/engine side (drives ready flags and engine count).
interface hwpe_tiled_fsm_if #(
    parameter int N_SRC  = 2,
    parameter int N_SNK  = 1,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic [N_SRC-1:0]        src_ready_start;
    logic [N_SRC-1:0]        src_req_start;
    logic [N_SRC*ADDR_W-1:0] src_base_addr;
    logic [N_SNK-1:0]        snk_ready_start;
    logic [N_SNK-1:0]        snk_req_start;
    logic [N_SNK*ADDR_W-1:0] snk_base_addr;
    logic                    eng_ready;
    logic [CNT_W-1:0]        eng_cnt;
    logic                    eng_start;
    logic                    eng_clear;
    logic                    eng_enable;

    modport master (
        input  src_ready_start, snk_ready_start, eng_ready, eng_cnt,
        output src_req_start, snk_req_start, src_base_addr, snk_base_addr,
        output eng_start, eng_clear, eng_enable
    );

    modport slave (
        output src_ready_start, snk_ready_start, eng_ready, eng_cnt,
        input  src_req_start, snk_req_start, src_base_addr, snk_base_addr,
        input  eng_start, eng_clear, eng_enable
    );
endinterface

// File: rtl/hwpe_tiled_fsm.sv
// Multi-tile HWPE control FSM: sequences N_SRC/N_SNK streamers and one engine
// over n_tiles tiles, advancing each stream base by its stride per tile.
// Ports: clk_i, rst_i (async, active-high), clear_i (sync), start_i,
//   job config (n_tiles_i, cnt_limit_i, src/snk base and stride),
//   status (tile_idx_o, busy_o, done_o, evt_o), watchdog (wdog_limit_i,
//   timeout_o), streamer/engine bundle via hwpe_tiled_fsm_if.master.
// Optional stall watchdog built when HWPE_FSM_WDOG_EN is defined.
module hwpe_tiled_fsm #(
    parameter int N_SRC  = 2,
    parameter int N_SNK  = 1,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32,
    parameter int TILE_W = 16,
    parameter int WDOG_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [TILE_W-1:0]       n_tiles_i,
    input  logic [CNT_W-1:0]        cnt_limit_i,
    input  logic [N_SRC*ADDR_W-1:0] src_base_i,
    input  logic [N_SRC*ADDR_W-1:0] src_stride_i,
    input  logic [N_SNK*ADDR_W-1:0] snk_base_i,
    input  logic [N_SNK*ADDR_W-1:0] snk_stride_i,
    input  logic [WDOG_W-1:0]       wdog_limit_i,
    output logic [TILE_W-1:0]       tile_idx_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    evt_o,
    output logic                    timeout_o,
    hwpe_tiled_fsm_if.master        strm
);

    typedef enum logic [2:0] {
        IDLE, WAIT, COMPUTE, UPDATE, DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [TILE_W-1:0] tile_q, n_tiles_q, tile_inc;
    logic [CNT_W-1:0]  cnt_limit_q;
    logic [N_SRC-1:0][ADDR_W-1:0] src_base_q, src_stride_q, src_addr_q;
    logic [N_SNK-1:0][ADDR_W-1:0] snk_base_q, snk_stride_q, snk_addr_q;

    logic all_ready, last_tile, ld, upd, done, timeout, wdog_hit;

    assign all_ready = (&strm.src_ready_start) & (&strm.snk_ready_start);
    assign tile_inc  = tile_q + TILE_W'(1);
    assign last_tile = (tile_inc == n_tiles_q);

    always_comb begin
        state_d            = state_q;
        strm.src_req_start = '0;
        strm.snk_req_start = '0;
        strm.eng_start     = 1'b0;
        strm.eng_clear     = 1'b0;
        strm.eng_enable    = 1'b0;
        done               = 1'b0;
        timeout            = 1'b0;
        ld                 = 1'b0;
        upd                = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // held low while in reset so every output resets to 0
                    strm.eng_clear = ~rst_i;
                    if (start_i) begin
                        ld      = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (all_ready) begin
                        strm.src_req_start = '1;
                        strm.snk_req_start = '1;
                        strm.eng_start     = 1'b1;
                        state_d            = COMPUTE;
                    end
                end
                COMPUTE: begin
                    strm.eng_enable = 1'b1;
                    strm.eng_start  = strm.eng_ready;
                    if (strm.eng_cnt == cnt_limit_q) state_d = UPDATE;
                end
                UPDATE: begin
                    if (last_tile) begin
                        state_d = DRAIN;
                    end else begin
                        strm.eng_clear = 1'b1;
                        upd            = 1'b1;
                        state_d        = WAIT;
                    end
                end
                DRAIN: begin
                    if (all_ready) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (wdog_hit) begin
                strm.src_req_start = '0;
                strm.snk_req_start = '0;
                strm.eng_start     = 1'b0;
                timeout            = 1'b1;
                done               = 1'b1;
                state_d            = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tile_q       <= '0;
            n_tiles_q    <= '0;
            cnt_limit_q  <= '0;
            src_base_q   <= '0;
            src_stride_q <= '0;
            src_addr_q   <= '0;
            snk_base_q   <= '0;
            snk_stride_q <= '0;
            snk_addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clear_i) begin
                tile_q     <= '0;
                src_addr_q <= src_base_q;
                snk_addr_q <= snk_base_q;
            end else if (ld) begin
                tile_q       <= '0;
                n_tiles_q    <= (n_tiles_i == '0) ? TILE_W'(1) : n_tiles_i;
                cnt_limit_q  <= cnt_limit_i;
                src_base_q   <= src_base_i;
                src_stride_q <= src_stride_i;
                snk_base_q   <= snk_base_i;
                snk_stride_q <= snk_stride_i;
                src_addr_q   <= src_base_i;
                snk_addr_q   <= snk_base_i;
            end else if (upd) begin
                // address tracks base + offset; ready for the next WAIT
                tile_q <= tile_inc;
                for (int i = 0; i < N_SRC; i++)
                    src_addr_q[i] <= src_addr_q[i] + src_stride_q[i];
                for (int i = 0; i < N_SNK; i++)
                    snk_addr_q[i] <= snk_addr_q[i] + snk_stride_q[i];
            end
        end
    end

`ifdef HWPE_FSM_WDOG_EN
    logic [WDOG_W-1:0] wdog_q;
    logic [CNT_W-1:0]  cnt_prev_q;
    logic              wdog_run;

    assign wdog_run = (state_q == WAIT) || (state_q == COMPUTE) ||
                      (state_q == DRAIN);
    assign wdog_hit = wdog_run && (wdog_limit_i != '0) &&
                      (wdog_q == wdog_limit_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q     <= '0;
            cnt_prev_q <= '0;
        end else begin
            cnt_prev_q <= strm.eng_cnt;
            if (!wdog_run || state_d != state_q ||
                strm.eng_cnt != cnt_prev_q)
                wdog_q <= '0;
            else
                wdog_q <= wdog_q + WDOG_W'(1);
        end
    end
`else
    logic wdog_unused;
    assign wdog_unused = ^wdog_limit_i;
    assign wdog_hit    = 1'b0;
`endif

    assign strm.src_base_addr = src_addr_q;
    assign strm.snk_base_addr = snk_addr_q;
    assign tile_idx_o         = tile_q;
    assign busy_o             = (state_q != IDLE);
    assign done_o             = done;
    assign evt_o              = done;
    assign timeout_o          = timeout;

endmodule
